// File: rtl/qrx_pkg.sv
// Shared constants, FSM state type and CRC-5 step function for the Query command receiver.
package qrx_pkg;

   localparam logic [4:0] CRC5_PRESET = 5'b01001;
   localparam logic [3:0] QUERY_CMD   = 4'b1000;
   localparam int         QUERY_LEN   = 22;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2,
      SKIP  = 2'd3
   } state_t;

   // One serial step of the x^5 + x^3 + 1 register, MSB-first input.
   function automatic logic [4:0] crc5Step(input logic [4:0] c, input logic b);
      logic fb;
      fb = b ^ c[4];
      return {c[3], c[2] ^ fb, c[1], c[0], fb};
   endfunction

endpackage

// File: rtl/crc5_lfsr.sv
// Serial CRC-5 register. init reloads the preset and wins over en; an init cycle that also
// carries a valid bit loads the preset already advanced by that bit.
module crc5_lfsr
   import qrx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       init,
   input  logic       en,
   input  logic       bitin,
   output logic [4:0] crc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= CRC5_PRESET;
      end else if (init) begin
         crc <= en ? crc5Step(CRC5_PRESET, bitin) : CRC5_PRESET;
      end else if (en) begin
         crc <= crc5Step(crc, bitin);
      end
   end

endmodule

// File: rtl/query_crc5_rx.sv
// Query command receiver: collects a serial frame, checks opcode and CRC-5, latches Query fields.
// Optional build macro QRX_CRC_DEBUG_EN adds output crc_dbg carrying the live CRC register.
module query_crc5_rx
   import qrx_pkg::*;
#(
   parameter int         CMD_LEN  = QUERY_LEN,
   parameter logic [3:0] CMD_CODE = QUERY_CMD
)
(
   input  logic       crcinclk,
   input  logic       reset,
   input  logic       framestart,
   input  logic       bitvalid,
   input  logic       bitin,
   output logic       busy,
   output logic       query_ok,
   output logic       crc_err,
   output logic       cmd_mismatch,
   output logic       dr,
   output logic [1:0] m,
   output logic       trext,
   output logic [1:0] sel,
   output logic [1:0] session,
   output logic       target,
   output logic [3:0] q
`ifdef QRX_CRC_DEBUG_EN
   ,
   output logic [4:0] crc_dbg
`endif
);

   localparam logic [4:0] LAST_IDX    = 5'(CMD_LEN - 1);
   localparam logic [4:0] PAYLOAD_LEN = 5'(CMD_LEN - 5);

   state_t      r_state;
   logic [4:0]  r_count;
   logic [16:0] r_payload;
   logic        r_queryOk;
   logic        r_crcErr;
   logic        r_cmdMismatch;
   logic [12:0] r_fields;
   logic [4:0]  w_crc;
   logic        w_crcEn;
   logic [3:0]  w_opcode;

   // A framestart cycle may carry frame bit 0; otherwise bits only count while receiving.
   assign w_crcEn  = framestart ? bitvalid : ((r_state == RECV) && bitvalid);
   assign w_opcode = {r_payload[2:0], bitin};

   crc5_lfsr u_crc (
      .clk   (crcinclk),
      .rst   (reset),
      .init  (framestart),
      .en    (w_crcEn),
      .bitin (bitin),
      .crc   (w_crc)
   );

   // Payload holds only the non-CRC bits, frame bit k at index 16-k once the frame is complete.
   always_ff @(posedge crcinclk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_count       <= '0;
         r_payload     <= '0;
         r_queryOk     <= 1'b0;
         r_crcErr      <= 1'b0;
         r_cmdMismatch <= 1'b0;
         r_fields      <= '0;
      end else begin
         r_queryOk     <= 1'b0;
         r_crcErr      <= 1'b0;
         r_cmdMismatch <= 1'b0;
         if (framestart) begin
            r_state   <= RECV;
            r_count   <= bitvalid ? 5'd1 : 5'd0;
            r_payload <= bitvalid ? {16'd0, bitin} : 17'd0;
         end else begin
            case (r_state)
               RECV: begin
                  if (bitvalid) begin
                     r_count <= r_count + 5'd1;
                     if (r_count < PAYLOAD_LEN) begin
                        r_payload <= {r_payload[15:0], bitin};
                     end
                     if ((r_count == 5'd3) && (w_opcode != CMD_CODE)) begin
                        r_state       <= SKIP;
                        r_cmdMismatch <= 1'b1;
                     end else if (r_count == LAST_IDX) begin
                        r_state <= CHECK;
                     end
                  end
               end
               CHECK: begin
                  r_state <= IDLE;
                  if ((w_crc == 5'd0) && (r_payload[16:13] == CMD_CODE)) begin
                     r_queryOk <= 1'b1;
                     r_fields  <= r_payload[12:0];
                  end else begin
                     r_crcErr <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign busy         = (r_state == RECV);
   assign query_ok     = r_queryOk;
   assign crc_err      = r_crcErr;
   assign cmd_mismatch = r_cmdMismatch;
   assign {dr, m, trext, sel, session, target, q} = r_fields;

`ifdef QRX_CRC_DEBUG_EN
   assign crc_dbg = w_crc;
`endif

endmodule

// File: tb/tb_query_crc5_rx.sv
// Self-checking bench for query_crc5_rx: directed vector table, multi-cycle corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_query_crc5_rx;

   logic       crcinclk   = 1'b0;
   logic       reset      = 1'b1;
   logic       framestart = 1'b0;
   logic       bitvalid   = 1'b0;
   logic       bitin      = 1'b0;
   logic       busy, query_ok, crc_err, cmd_mismatch;
   logic       dr, trext, target;
   logic [1:0] m, sel, session;
   logic [3:0] q;
`ifdef QRX_CRC_DEBUG_EN
   logic [4:0] crc_dbg;
`endif

   int testsRun    = 0;
   int testsFailed = 0;
   int cycleCount  = 0;
   int nQok, nErr, nMis, nMulti;
   int qokCycle, errCycle, misCycle;
   logic [12:0] expFields = '0;
   logic [12:0] w_fields;

   localparam logic [21:0] VALID_FRAME = 22'b1000000000000000010000;

   always #5 crcinclk = ~crcinclk;

   query_crc5_rx dut (
      .crcinclk     (crcinclk),
      .reset        (reset),
      .framestart   (framestart),
      .bitvalid     (bitvalid),
      .bitin        (bitin),
      .busy         (busy),
      .query_ok     (query_ok),
      .crc_err      (crc_err),
      .cmd_mismatch (cmd_mismatch),
      .dr           (dr),
      .m            (m),
      .trext        (trext),
      .sel          (sel),
      .session      (session),
      .target       (target),
      .q            (q)
`ifdef QRX_CRC_DEBUG_EN
      ,
      .crc_dbg      (crc_dbg)
`endif
   );

   assign w_fields = {dr, m, trext, sel, session, target, q};

   typedef struct {
      string       name;
      logic [21:0] frame;
      int          firstBit;
      int          maxGap;
      int          expQ;
      int          expE;
      int          expM;
   } vec_t;

   // Reference CRC: frame bits fed MSB first from the preset, using the defined register update.
   function automatic logic [4:0] crcModel(input logic [21:0] f);
      logic [4:0] c;
      logic       fb;
      c = 5'b01001;
      for (int k = 0; k < 22; k++) begin
         fb = f[21-k] ^ c[4];
         c  = {c[3], c[2] ^ fb, c[1], c[0], fb};
      end
      return c;
   endfunction

   function automatic logic [21:0] makeValid(input logic [16:0] payload);
      logic [21:0] f;
      f = {payload, 5'd0};
      for (int cand = 0; cand < 32; cand++) begin
         f = {payload, 5'(cand)};
         if (crcModel(f) == 5'd0) return f;
      end
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge crcinclk);
      #1;
      cycleCount++;
      if (query_ok)     begin nQok++; qokCycle = cycleCount; end
      if (crc_err)      begin nErr++; errCycle = cycleCount; end
      if (cmd_mismatch) begin nMis++; misCycle = cycleCount; end
      if (int'(query_ok) + int'(crc_err) + int'(cmd_mismatch) > 1) nMulti++;
   endtask

   task automatic clearCounts();
      nQok = 0; nErr = 0; nMis = 0; nMulti = 0;
      qokCycle = -1; errCycle = -1; misCycle = -1;
   endtask

   task automatic applyStimulus(input logic [21:0] frame, input int firstBit, input int maxGap,
                                output int lastBitCycle, output int bit3Cycle);
      int gapN;
      clearCounts();
      lastBitCycle = -1;
      bit3Cycle    = -1;
      framestart = 1'b1;
      bitvalid   = (firstBit == 1);
      bitin      = frame[21];
      tick();
      framestart = 1'b0;
      bitvalid   = 1'b0;
      for (int k = firstBit; k < 22; k++) begin
         gapN = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
         for (int g = 0; g < gapN; g++) begin
            bitin = 1'($urandom);
            tick();
         end
         bitvalid = 1'b1;
         bitin    = frame[21-k];
         tick();
         bitvalid = 1'b0;
         if (k == 3)  bit3Cycle    = cycleCount;
         if (k == 21) lastBitCycle = cycleCount;
      end
      repeat (3) tick();
   endtask

   task automatic sendPartial(input logic [21:0] frame, input int n);
      framestart = 1'b1;
      bitvalid   = 1'b0;
      tick();
      framestart = 1'b0;
      for (int k = 0; k < n; k++) begin
         bitvalid = 1'b1;
         bitin    = frame[21-k];
         tick();
      end
      bitvalid = 1'b0;
   endtask

   // Frame-level expectations: opcode gate first, then CRC residue decides the outcome.
   task automatic checkFrame(input string tag, input logic [21:0] frame, input int lastBitCycle, input int bit3Cycle);
      bit opOk, expQ, expE, expM;
      opOk = (frame[21:18] == 4'b1000);
      expQ = opOk && (crcModel(frame) == 5'd0);
      expE = opOk && (crcModel(frame) != 5'd0);
      expM = !opOk;
      checkOutput({tag, " query_ok count"}, nQok, expQ);
      checkOutput({tag, " crc_err count"}, nErr, expE);
      checkOutput({tag, " cmd_mismatch count"}, nMis, expM);
      checkOutput({tag, " exclusive pulses"}, nMulti, 0);
      if (expQ) begin
         checkOutput({tag, " query_ok cycle"}, qokCycle, lastBitCycle + 1);
         expFields = frame[17:5];
      end
      if (expE) checkOutput({tag, " crc_err cycle"}, errCycle, lastBitCycle + 1);
      if (expM) checkOutput({tag, " cmd_mismatch cycle"}, misCycle, bit3Cycle);
      checkOutput({tag, " fields"}, w_fields, expFields);
      checkOutput({tag, " busy after frame"}, busy, 0);
   endtask

   initial begin
      vec_t        vecs[5];
      int          lastC, bit3C;
      logic [16:0] payload;
      logic [21:0] frame;

      vecs[0] = '{"valid",         VALID_FRAME,              0, 0, 1, 0, 0};
      vecs[1] = '{"corrupt crc",   22'b1000000000000000010001, 0, 0, 0, 1, 0};
      vecs[2] = '{"wrong opcode",  22'b1001000000000000010000, 0, 0, 0, 0, 1};
      vecs[3] = '{"valid gaps",    VALID_FRAME,              0, 3, 1, 0, 0};
      vecs[4] = '{"start with bit", VALID_FRAME,             1, 0, 1, 0, 0};

      clearCounts();
      repeat (2) tick();
      checkOutput("reset busy", busy, 0);
      checkOutput("reset pulses", nQok + nErr + nMis, 0);
      checkOutput("reset fields", w_fields, 0);
`ifdef QRX_CRC_DEBUG_EN
      checkOutput("reset crc", crc_dbg, 5'b01001);
`endif
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].frame, vecs[i].firstBit, vecs[i].maxGap, lastC, bit3C);
         checkOutput({vecs[i].name, " table query_ok"}, nQok, vecs[i].expQ);
         checkOutput({vecs[i].name, " table crc_err"}, nErr, vecs[i].expE);
         checkOutput({vecs[i].name, " table cmd_mismatch"}, nMis, vecs[i].expM);
         checkFrame(vecs[i].name, vecs[i].frame, lastC, bit3C);
      end

      // Reset mid-frame: frame dropped silently, next cycle's framestart honoured.
      clearCounts();
      sendPartial(VALID_FRAME, 11);
      checkOutput("midreset busy before", busy, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("midreset async busy", busy, 0);
`ifdef QRX_CRC_DEBUG_EN
      checkOutput("midreset crc", crc_dbg, 5'b01001);
`endif
      tick();
      reset     = 1'b0;
      expFields = '0;
      checkOutput("midreset pulses", nQok + nErr + nMis, 0);
      applyStimulus(VALID_FRAME, 0, 0, lastC, bit3C);
      checkFrame("after reset", VALID_FRAME, lastC, bit3C);

      // Restart mid-frame with framestart carrying bit 0.
      clearCounts();
      sendPartial(VALID_FRAME, 7);
      applyStimulus(VALID_FRAME, 1, 0, lastC, bit3C);
      checkFrame("restart", VALID_FRAME, lastC, bit3C);

      for (int r = 0; r < 30; r++) begin
         payload = 17'($urandom);
         if ($urandom_range(0, 4) != 0) payload[16:13] = 4'b1000;
         frame = makeValid(payload);
         if ($urandom_range(0, 2) == 0) frame[$urandom_range(0, 21)] ^= 1'b1;
         applyStimulus(frame, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), lastC, bit3C);
         checkFrame($sformatf("random %0d", r), frame, lastC, bit3C);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/query_crc5_rx.md
QUERY_CRC5_RX -- requirements
Module: query_crc5_rx

Interface
REQ-001 Parameter CMD_LEN, default 22, total command bits including the 5-bit CRC.
REQ-002 Parameter CMD_CODE, default 4'b1000, expected 4-bit Query opcode.
REQ-003 crcinclk  in  1  bit clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces the reset state of REQ-020.
REQ-005 framestart  in  1  synchronous frame restart, sampled on crcinclk.
REQ-006 bitvalid  in  1  bitin carries a valid command bit this cycle.
REQ-007 bitin  in  1  serial command bit, MSB first.
REQ-008 busy  out  1  high while in RECV.
REQ-009 query_ok  out  1  one-cycle pulse: full frame received with CRC residue 00000.
REQ-010 crc_err  out  1  one-cycle pulse: full frame received with non-zero residue.
REQ-011 cmd_mismatch  out  1  one-cycle pulse: first 4 bits differ from CMD_CODE.
REQ-012 dr, m[1:0], trext, sel[1:0], session[1:0], target, q[3:0]  out  Query fields, updated only with query_ok.

Function
REQ-013 The block SHALL use FSM states IDLE, RECV, CHECK and SKIP.
REQ-014 framestart SHALL preset the CRC to 5'b01001, clear the bit counter and enter RECV from any state. If bitvalid is high in the same cycle, that bit SHALL be taken as frame bit 0.
REQ-015 In RECV, each bitvalid SHALL advance the CRC as follows: fb=bitin^c[4]; c0<=fb; c1<=c0; c2<=c1; c3<=c2^fb; c4<=c3. The bit counter SHALL increment and the bit SHALL shift into a 17-bit payload register.
REQ-016 When the 4th bit is accepted and the opcode differs from CMD_CODE, the block SHALL pulse cmd_mismatch in the next cycle and enter SKIP.
REQ-017 When bit CMD_LEN-1 is accepted, the block SHALL enter CHECK. In the next cycle it SHALL pulse query_ok if the CRC equals 00000, otherwise crc_err, and then return to IDLE.
REQ-018 On query_ok, the block SHALL latch payload bits 4..16 as dr, m, trext, sel, session, target, q (bit 4=dr, bits 5-6=m, bit 7=trext, bits 8-9=sel, bits 10-11=session, bit 12=target, bits 13-16=q). On crc_err the fields SHALL hold their previous values.
REQ-019 In IDLE and SKIP, bitvalid SHALL be ignored; only framestart leaves these states. The 5-bit counter SHALL never wrap within a frame. query_ok, crc_err and cmd_mismatch SHALL be mutually exclusive.

Reset
REQ-020 On reset, the state SHALL be IDLE and the CRC SHALL be 5'b01001. Counter, payload, all field outputs, busy and all pulses SHALL be 0.
REQ-021 A reset asserted mid-frame SHALL discard the frame with no pulse emitted. The first cycle after reset deassertion SHALL honour framestart.

Configuration
REQ-022 With QRX_CRC_DEBUG_EN defined, the block SHALL add output crc_dbg[4:0] carrying the live CRC register. Without it, the port and logic SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-023 Package qrx_pkg SHALL hold CRC5_PRESET=5'b01001, QUERY_CMD=4'b1000, QUERY_LEN=22 and the FSM state enum.
REQ-024 The CRC SHALL be a sub-module crc5_lfsr (inputs clk, rst, init, en, bitin; output crc[4:0]). Its init input SHALL take priority over en.

Verification
REQ-025 Valid Query: framestart, then bits 1000000000000000010000 -> query_ok one cycle after bit 21, CRC 00000, all fields 0.
REQ-026 Corrupted CRC: same frame with last bit 1 -> crc_err pulse, no query_ok, fields unchanged.
REQ-027 Wrong opcode: bits 1001... -> cmd_mismatch after bit 3, later bits ignored, no query_ok or crc_err.
REQ-028 Reset after bit 10 of a valid frame -> CRC 01001, IDLE, no pulse. A following full valid frame -> query_ok.
REQ-029 framestart with bitvalid=1 and bitin=1 mid-frame -> restart; that bit counts as bit 0, and a 21-bit continuation of the valid vector -> query_ok.
REQ-030 Gaps with bitvalid=0 between bits of the valid frame -> identical result to REQ-025.
